// File: rtl/etcpu_mem_pkg.sv
// Shared types and helpers for the CPU main-memory port.
// The write-buffer index field is sized for the widest word index a 32-bit byte address can carry.
package etcpu_mem_pkg;

    localparam int MEM_WORD_W = 32;
    localparam int IDX_W      = 30;

    typedef struct packed {
        logic                  vld;
        logic [IDX_W-1:0]      idx;
        logic [MEM_WORD_W-1:0] dat;
    } wbuf_t;

    // The limit is computed in 34 bits so that BASE+4*DEPTH cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [31:0] off;
        logic [33:0] lim;
        off = addr - base;
        lim = {depth[31:0], 2'b00};
        return (addr >= base) && ({2'b00, off} < lim);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one asynchronous read port and one synchronous write port.
// The array has no reset, so its contents survive a reset.
module dmem_array
    import etcpu_mem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [MEM_WORD_W-1:0] wdat,
    input  logic [AW-1:0]         raddr,
    output logic [MEM_WORD_W-1:0] rdat
);

    logic [MEM_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one-entry posted write buffer with read forwarding,
// zero-latency read data, sticky range/alignment error flags and access counters.
module dmem_responder
    import etcpu_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_cs,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dat_in,
    output logic [31:0] mem_dat_out,
    input  logic        err_clr,
    output logic        err_range,
    output logic        err_align,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic          acc;
    logic          in_range;
    logic          aligned;
    logic          valid;
    logic          rd_ok;
    logic          wr_ok;
    logic          fwd_hit;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [31:0]   arr_rdat;
    wbuf_t         wb;

    // chip-select is ignored during reset so the read path stays quiet
    assign acc      = mem_cs & ~rst;
    assign in_range = addr_in_range(mem_addr, BASE_ADDR, DEPTH);
    assign aligned  = (mem_addr[1:0] == 2'b00);
    assign valid    = acc & in_range & aligned;
    assign rd_ok    = valid & ~mem_wen;
    assign wr_ok    = valid & mem_wen;

    assign off = mem_addr - BASE_ADDR;
    assign idx = AW'(off >> 2);

    assign fwd_hit     = wb.vld && (wb.idx == IDX_W'(idx));
    assign mem_dat_out = rd_ok ? (fwd_hit ? wb.dat : arr_rdat) : '0;

    // A valid buffer always drains on the next edge, whether or not a new write replaces it.
    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wb.vld),
        .waddr (AW'(wb.idx)),
        .wdat  (wb.dat),
        .raddr (idx),
        .rdat  (arr_rdat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb <= '0;
        end else if (wr_ok) begin
            wb <= {1'b1, IDX_W'(idx), mem_dat_in};
        end else begin
            wb.vld <= 1'b0;
        end
    end

    // set has priority over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else begin
            if (acc && !in_range) begin
                err_range <= 1'b1;
            end else if (err_clr) begin
                err_range <= 1'b0;
            end
            if (acc && !aligned) begin
                err_align <= 1'b1;
            end else if (err_clr) begin
                err_align <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_ok) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_ok) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: an architectural memory model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_cs;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
    logic [31:0] mem_dat_out;
    logic        err_clr;
    logic        err_range;
    logic        err_align;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_cs      (mem_cs),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_dat_in  (mem_dat_in),
        .mem_dat_out (mem_dat_out),
        .err_clr     (err_clr),
        .err_range   (err_range),
        .err_align   (err_align),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt)
    );

    // Architectural model: writes are visible immediately; the only trace of the
    // posting buffer is that a write accepted on the edge just before reset is lost.
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_err_r;
    bit          m_err_a;
    logic [31:0] m_rd;
    logic [31:0] m_wr;
    bit          undo_v;
    int          undo_idx;
    logic [31:0] undo_dat;
    bit          undo_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        longint lo;
        longint hi;
        lo = longint'(BASE);
        hi = lo + 4 * longint'(DEPTH);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(((longint'(a) - longint'(BASE)) / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        if (undo_v) begin
            m_mem[undo_idx]   = undo_dat;
            m_known[undo_idx] = undo_known;
        end
        undo_v  = 0;
        m_err_r = 0;
        m_err_a = 0;
        m_rd    = '0;
        m_wr    = '0;
    endtask

    task automatic model_edge();
        bit inr;
        bit al;
        int i;
        if (rst) return;
        inr = m_in_range(mem_addr);
        al  = (mem_addr % 4) == 0;
        if (mem_cs && !inr) m_err_r = 1;
        else if (err_clr)   m_err_r = 0;
        if (mem_cs && !al)  m_err_a = 1;
        else if (err_clr)   m_err_a = 0;
        undo_v = 0;
        if (mem_cs && inr && al) begin
            i = m_idx(mem_addr);
            if (mem_wen) begin
                undo_v     = 1;
                undo_idx   = i;
                undo_dat   = m_mem[i];
                undo_known = m_known[i];
                m_mem[i]   = mem_dat_in;
                m_known[i] = 1;
                m_wr       = m_wr + 1;
            end else begin
                m_rd = m_rd + 1;
            end
        end
    endtask

    task automatic model_compare();
        int i;
        if (!rst && mem_cs && !mem_wen && m_in_range(mem_addr) && (mem_addr % 4) == 0) begin
            i = m_idx(mem_addr);
            if (m_known[i]) chk("rd_data", mem_dat_out, m_mem[i]);
        end else begin
            chk("rd_data_zero", mem_dat_out, 32'h0);
        end
        chk("err_range", {31'b0, err_range}, {31'b0, m_err_r});
        chk("err_align", {31'b0, err_align}, {31'b0, m_err_a});
        chk("rd_cnt", rd_cnt, m_rd);
        chk("wr_cnt", wr_cnt, m_wr);
    endtask

    task automatic drive(input logic cs, input logic wen, input logic [31:0] a,
                         input logic [31:0] d, input logic clr);
        mem_cs     = cs;
        mem_wen    = wen;
        mem_addr   = a;
        mem_dat_in = d;
        err_clr    = clr;
    endtask

    // one clock cycle: model sees the edge, new inputs (and reset level) apply, outputs checked mid-cycle
    task automatic step(input logic r, input logic cs, input logic wen, input logic [31:0] a,
                        input logic [31:0] d, input logic clr);
        @(posedge clk);
        model_edge();
        #1;
        if (r && !rst) model_reset();
        rst = r;
        drive(cs, wen, a, d, clr);
        @(negedge clk);
        model_compare();
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic clr);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, clr);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        undo_v = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();

        // reset state, including cs ignored while in reset
        idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("reset_dat_out", mem_dat_out, 32'h0);
        chk("reset_rd_cnt", rd_cnt, 32'h0);
        idle(1'b0);

        // 1: forward from buffer, then read from array
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 1'b0);
        chk("t1_forward", mem_dat_out, 32'hDEAD_BEEF);
        idle(1'b0);
        rd(32'h10, 1'b0);
        chk("t1_array", mem_dat_out, 32'hDEAD_BEEF);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // 2: back-to-back writes, same word rewritten
        wr(32'h0, 32'd1);
        wr(32'h4, 32'd2);
        wr(32'h0, 32'd3);
        rd(32'h0, 1'b0);
        chk("t2_rd0", mem_dat_out, 32'd3);
        rd(32'h4, 1'b0);
        chk("t2_rd4", mem_dat_out, 32'd2);
        idle(1'b0);
        chk("t2_wr_cnt", wr_cnt, 32'd3);
        chk("t2_rd_cnt", rd_cnt, 32'd2);

        // 3: misaligned read, clear, clear racing a new error
        rd(32'h2, 1'b0);
        chk("t3_dat_zero", mem_dat_out, 32'h0);
        idle(1'b0);
        chk("t3_align_set", {31'b0, err_align}, 32'd1);
        chk("t3_rd_cnt", rd_cnt, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(1'b0);
        chk("t3_align_clr", {31'b0, err_align}, 32'd0);
        rd(32'h6, 1'b1);
        idle(1'b0);
        chk("t3_set_wins", {31'b0, err_align}, 32'd1);

        // 4: out-of-range write must not alias onto word 0
        wr(BASE + 4 * DEPTH, 32'h55);
        idle(1'b0);
        chk("t4_range_set", {31'b0, err_range}, 32'd1);
        chk("t4_wr_cnt", wr_cnt, 32'd3);
        rd(32'h0, 1'b0);
        chk("t4_no_alias", mem_dat_out, 32'd3);
        if (mem_dat_out == 32'h55) chk("t4_not_55", mem_dat_out, 32'd3);

        // 5: pending write discarded by reset
        wr(32'h8, 32'hAAAA_5555);
        idle(1'b0);
        idle(1'b0);
        wr(32'h8, 32'h1234);
        idle(1'b1);
        idle(1'b1);
        rd(32'h8, 1'b0);
        chk("t5_prior_val", mem_dat_out, 32'hAAAA_5555);
        chk("t5_rd_cnt", rd_cnt, 32'd0);
        chk("t5_wr_cnt", wr_cnt, 32'd0);
        chk("t5_err_range", {31'b0, err_range}, 32'd0);
        chk("t5_err_align", {31'b0, err_align}, 32'd0);
        idle(1'b0);

        // 6: read counter wraps
        @(posedge clk);
        model_edge();
        #1;
        force dut.rd_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt;
        m_rd = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        model_compare();
        chk("t6_preload", rd_cnt, 32'hFFFF_FFFF);
        idle(1'b0);
        chk("t6_wrap", rd_cnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
